jc_seq_ctrl: RTL and testbench
==============================

// Module: jc_seq_ctrl
// PURPOSE
//  Controller that sequences a WIDTH-bit Johnson (twisted-ring) counter for multi-phase enable generation.
//  Accepts a start command with run length, step rate and direction. Paces the ring via a prescaler and
//  counts full revolutions. Supports graceful stop (drain to all-zero) and flags illegal ring codes.
// PARAMETERS
//  WIDTH   4  Johnson ring width; ring has 2*WIDTH states
//  REV_W   8  width of revolution count (cfg_revs)
//  DIV_W   8  width of prescaler divide value (cfg_div)
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  start      in   1      start command; sampled only in IDLE
//  cfg_revs   in   REV_W  revolutions to run; 0 = run until stop_req
//  cfg_div    in   DIV_W  ring advances once every cfg_div+1 cycles
//  cfg_dir    in   1      0: 0000->1000->1100..; 1: 0000->0001->0011..
//  stop_req   in   1      graceful stop; sampled only in RUN
//  busy       out  1      state != IDLE
//  done       out  1      1-cycle pulse on completion
//  q          out  WIDTH  Johnson ring value
//  step       out  1      1-cycle pulse aligned with each new q value
//  wrap       out  1      1-cycle pulse aligned with q returning to all-zero
//  err_illegal out 1      sticky: q held an illegal code; cleared on accepted start
// BEHAVIOUR
//  - Reset: state IDLE; q=0, busy=0, done=0, step=0, wrap=0, err_illegal=0; prescaler/rev count 0.
//  - FSM: IDLE -start-> RUN; RUN -stop_req-> DRAIN; RUN/DRAIN -final wrap-> DONE; DONE -> IDLE (1 cycle).
//  - Start in IDLE: latch cfg_revs/cfg_div/cfg_dir, q<=0, prescaler<=0, rev count<=0, err_illegal<=0.
//  - Advance when prescaler==div_latched (prescaler then reloads 0, else increments); only in RUN/DRAIN.
//    div=0: first advance on the edge after the start edge; div=N: every N+1 cycles.
//  - dir0: q<={~q[0],q[W-1:1]}; dir1: q<={q[W-2:0],~q[W-1]}. step, wrap, done are registered, same edge as q.
//  - Advance into all-zero: wrap=1, rev count+1; if cfg_revs!=0 and count reaches cfg_revs -> DONE, done=1.
//  - stop_req in RUN: if q==0 -> DONE next edge (done=1, no advance); else -> DRAIN, keep pace until q==0.
//  - stop_req on the same edge as the final-revolution wrap: DONE (single done pulse).
//  - start while busy: ignored. stop_req in IDLE/DRAIN/DONE: ignored. start+stop same cycle in IDLE: start wins.
//  - Legal code: at most one 0/1 transition across adjacent bits q[i]/q[i+1] (non-circular), i.e. 2*WIDTH codes.
//    Illegal q while busy: err_illegal<=1, q<=0 next edge, FSM -> DONE (done=1). Runs are never silently corrupted.
//  - cfg_* changes after start have no effect until the next accepted start.
//  - rst_n assertion mid-run: immediate return to reset values; no done pulse.
// STRUCTURE
//  - jc_pkg: FSM state localparams (IDLE/RUN/DRAIN/DONE, binary); function jc_is_legal(q) per legal-code rule.
//  - Sub-module jc_core: Johnson ring register with adv, dir, clr inputs; q and legal outputs.
//  - jc_seq_ctrl: FSM, prescaler, revolution counter and pulse registers. jc_core is its only instance.
// TESTING
//  - W=4,div=0,revs=1,dir=0, start@c0 -> q 1000,1100,1110,1111,0111,0011,0001,0000 on c1..c8; wrap+done@c8.
//  - Same with dir=1 -> q 0001,0011,0111,1111,1110,1100,1000,0000 on c1..c8.
//  - div=2, revs=2 -> step every 3 cycles; 16 steps; wrap at steps 8 and 16; done with the 2nd wrap only.
//  - revs=0, stop_req when q=1110 -> DRAIN; advances 1111..0000 (5 more steps); done with that wrap; busy low next.
//  - Stop timing: stop_req when q=0000 in RUN -> done next cycle, no step. start during RUN -> no effect.
//  - Error/reset: force q=0100 -> err_illegal=1, q=0000, done; new start clears err. rst_n low mid-run -> all outputs 0.

Source files
------------

// File: rtl/jc_pkg.sv
// Shared FSM state codes and the Johnson legal-code check for the ring sequencer.
package jc_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int JC_MAX_W = 32;

    // A Johnson code has at most one 0/1 boundary between adjacent bits (non-circular).
    function automatic logic jc_is_legal(input logic [JC_MAX_W-1:0] code, input int width);
        int edges;
        edges = 0;
        for (int i = 0; i < JC_MAX_W - 1; i++) begin
            if (i < width - 1 && code[i] != code[i+1]) begin
                edges++;
            end
        end
        return (edges <= 1);
    endfunction

endpackage

// File: rtl/jc_seq_ctrl_if.sv
// Command/status bundle between a host and the Johnson ring sequencer.
interface jc_seq_ctrl_if #(
    parameter int WIDTH = 4,
    parameter int REV_W = 8,
    parameter int DIV_W = 8
);
    logic             start;
    logic [REV_W-1:0] cfg_revs;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_dir;
    logic             stop_req;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] q;
    logic             step;
    logic             wrap;
    logic             err_illegal;

    modport master (
        output start, cfg_revs, cfg_div, cfg_dir, stop_req,
        input  busy, done, q, step, wrap, err_illegal
    );

    modport slave (
        input  start, cfg_revs, cfg_div, cfg_dir, stop_req,
        output busy, done, q, step, wrap, err_illegal
    );
endinterface

// File: rtl/jc_core.sv
// Johnson ring register: shifts one position per adv in the chosen direction, clr wins over adv.
module jc_core
    import jc_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv,
    input  logic             dir,
    input  logic             clr,
    output logic [WIDTH-1:0] q,
    output logic             legal
);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] shift_dn;
    logic [WIDTH-1:0] shift_up;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
            assign shift_dn[gi]   = q_reg[gi+1];
            assign shift_up[gi+1] = q_reg[gi];
        end
    endgenerate

    // Twisted feedback: the bit falling off one end re-enters inverted at the other.
    assign shift_dn[WIDTH-1] = ~q_reg[0];
    assign shift_up[0]       = ~q_reg[WIDTH-1];

    always_comb begin
        q_next = q_reg;
        if (clr) begin
            q_next = '0;
        end else if (adv) begin
            q_next = dir ? shift_up : shift_dn;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg <= '0;
        end else begin
            q_reg <= q_next;
        end
    end

    assign q     = q_reg;
    assign legal = jc_is_legal(JC_MAX_W'(q), WIDTH);

endmodule

// File: rtl/jc_seq_ctrl.sv
// Run controller for a Johnson ring: start/stop FSM, step prescaler, revolution counter, status pulses.
module jc_seq_ctrl
    import jc_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int REV_W = 8,
    parameter int DIV_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    jc_seq_ctrl_if.slave  bus
);

    logic [1:0]       state_reg, state_next;
    logic [DIV_W-1:0] presc_reg, presc_next;
    logic [REV_W-1:0] rev_reg, rev_next;
    logic [REV_W-1:0] revs_reg, revs_next;
    logic [DIV_W-1:0] div_reg, div_next;
    logic             dir_reg, dir_next;
    logic             step_reg, step_next;
    logic             wrap_reg, wrap_next;
    logic             done_reg, done_next;
    logic             err_reg, err_next;

    logic             core_adv;
    logic             core_clr;
    logic [WIDTH-1:0] ring_q;
    logic             ring_legal;

    logic             tick;
    logic             stop_run;
    logic [REV_W-1:0] rev_inc;
    logic [WIDTH-1:0] last_code;

    jc_core #(.WIDTH(WIDTH)) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .adv   (core_adv),
        .dir   (dir_reg),
        .clr   (core_clr),
        .q     (ring_q),
        .legal (ring_legal)
    );

    assign tick     = (presc_reg == div_reg);
    assign stop_run = (state_reg == ST_RUN) && bus.stop_req;
    assign rev_inc  = rev_reg + 1'b1;
    // The code one step before all-zero; advancing from it completes a revolution.
    assign last_code = dir_reg ? {1'b1, {(WIDTH-1){1'b0}}} : {{(WIDTH-1){1'b0}}, 1'b1};

    always_comb begin
        state_next = state_reg;
        presc_next = presc_reg;
        rev_next   = rev_reg;
        revs_next  = revs_reg;
        div_next   = div_reg;
        dir_next   = dir_reg;
        err_next   = err_reg;
        step_next  = 1'b0;
        wrap_next  = 1'b0;
        done_next  = 1'b0;
        core_adv   = 1'b0;
        core_clr   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    state_next = ST_RUN;
                    revs_next  = bus.cfg_revs;
                    div_next   = bus.cfg_div;
                    dir_next   = bus.cfg_dir;
                    presc_next = '0;
                    rev_next   = '0;
                    err_next   = 1'b0;
                    core_clr   = 1'b1;
                end
            end
            ST_RUN, ST_DRAIN: begin
                if (!ring_legal) begin
                    err_next   = 1'b1;
                    core_clr   = 1'b1;
                    state_next = ST_DONE;
                    done_next  = 1'b1;
                end else if (stop_run && ring_q == '0) begin
                    state_next = ST_DONE;
                    done_next  = 1'b1;
                end else begin
                    presc_next = tick ? '0 : presc_reg + 1'b1;
                    core_adv   = tick;
                    step_next  = tick;
                    if (tick && ring_q == last_code) begin
                        wrap_next = 1'b1;
                        rev_next  = rev_inc;
                        // A stop arriving on a wrap edge is already drained, so it finishes here.
                        if (state_reg == ST_DRAIN || stop_run ||
                            (revs_reg != '0 && rev_inc == revs_reg)) begin
                            state_next = ST_DONE;
                            done_next  = 1'b1;
                        end
                    end else if (stop_run) begin
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
                if (!ring_legal) begin
                    err_next = 1'b1;
                    core_clr = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            presc_reg <= '0;
            rev_reg   <= '0;
            revs_reg  <= '0;
            div_reg   <= '0;
            dir_reg   <= 1'b0;
            step_reg  <= 1'b0;
            wrap_reg  <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            presc_reg <= presc_next;
            rev_reg   <= rev_next;
            revs_reg  <= revs_next;
            div_reg   <= div_next;
            dir_reg   <= dir_next;
            step_reg  <= step_next;
            wrap_reg  <= wrap_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
        end
    end

    assign bus.busy        = (state_reg != ST_IDLE);
    assign bus.done        = done_reg;
    assign bus.q           = ring_q;
    assign bus.step        = step_reg;
    assign bus.wrap        = wrap_reg;
    assign bus.err_illegal = err_reg;

endmodule

// File: tb/tb_jc_seq_ctrl.sv
// Self-checking bench for jc_seq_ctrl: directed tables, corner sequences and a random run against a phase model.
module tb_jc_seq_ctrl;
    localparam int W  = 4;
    localparam int RW = 8;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    jc_seq_ctrl_if #(.WIDTH(W), .REV_W(RW), .DIV_W(DW)) bus ();

    jc_seq_ctrl #(.WIDTH(W), .REV_W(RW), .DIV_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: ring position as a phase index 0..2W-1, mode 0 idle/1 run/2 drain/3 done.
    int m_mode = 0, m_phase = 0, m_cnt = 0, m_revc = 0, m_revs = 0, m_div = 0;
    bit m_dir = 0, m_step = 0, m_wrap = 0, m_done = 0, m_err = 0;

    typedef struct {
        bit             dir;
        bit             start;
        logic [W-1:0]   q;
        bit             busy;
        bit             step;
        bit             wrap;
        bit             done;
    } vec_t;

    vec_t tbl[20];

    function automatic logic [31:0] mk(bit b, bit d, bit s, bit w, bit e, logic [W-1:0] qv);
        return 32'({b, d, s, w, e, qv});
    endfunction

    function automatic logic [31:0] obs();
        return 32'({bus.busy, bus.done, bus.step, bus.wrap, bus.err_illegal, bus.q});
    endfunction

    // Phase k of the ring holds n ones, n = k for the filling half and 2W-k for the emptying half.
    function automatic logic [W-1:0] phase_code(int k, bit d);
        int n, lo;
        n  = (k <= W) ? k : 2 * W - k;
        lo = (1 << n) - 1;
        if ((k <= W) != d) return W'(lo << (W - n));
        return W'(lo);
    endfunction

    function automatic logic [31:0] model_exp();
        return mk(m_mode != 0, m_done, m_step, m_wrap, m_err, phase_code(m_phase, m_dir));
    endfunction

    task automatic model_edge(input bit st, input bit sp);
        bit run_stop;
        m_step = 0; m_wrap = 0; m_done = 0;
        run_stop = (m_mode == 1) && sp;
        case (m_mode)
            0: if (st) begin
                m_mode = 1; m_revs = int'(bus.cfg_revs); m_div = int'(bus.cfg_div);
                m_dir = bus.cfg_dir; m_phase = 0; m_cnt = 0; m_revc = 0; m_err = 0;
            end
            1, 2: begin
                if (run_stop && m_phase == 0) begin
                    m_mode = 3; m_done = 1;
                end else if (m_cnt == m_div) begin
                    m_cnt = 0;
                    m_phase = (m_phase + 1) % (2 * W);
                    m_step = 1;
                    if (m_phase == 0) begin
                        m_wrap = 1;
                        m_revc++;
                        if (m_mode == 2 || run_stop || (m_revs != 0 && m_revc == m_revs)) begin
                            m_mode = 3; m_done = 1;
                        end
                    end else if (run_stop) m_mode = 2;
                end else begin
                    m_cnt++;
                    if (run_stop) m_mode = 2;
                end
            end
            default: m_mode = 0;
        endcase
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic cycle(input bit st, input bit sp);
        bus.start    = st;
        bus.stop_req = sp;
        @(posedge clk);
        #1;
        model_edge(st, sp);
    endtask

    task automatic set_cfg(input int revs, input int dv, input bit d);
        bus.cfg_revs = RW'(revs);
        bus.cfg_div  = DW'(dv);
        bus.cfg_dir  = d;
    endtask

    initial begin
        logic [W-1:0] seq0[8];
        logic [W-1:0] seq1[8];
        logic [W-1:0] drain_q[4];
        int steps, spacing_bad, done_cnt, done_step, runs;
        bit fin;
        logic [31:0] wrap_mask;

        seq0 = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};
        seq1 = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
        drain_q = '{4'b0111, 4'b0011, 4'b0001, 4'b0000};
        for (int d = 0; d < 2; d++) begin
            tbl[d*10] = '{dir: d[0], start: 1'b1, q: 4'b0000, busy: 1'b1, step: 1'b0, wrap: 1'b0, done: 1'b0};
            for (int k = 1; k <= 8; k++) begin
                tbl[d*10+k] = '{dir: d[0], start: 1'b0, q: (d == 0) ? seq0[k-1] : seq1[k-1],
                                busy: 1'b1, step: 1'b1, wrap: (k == 8), done: (k == 8)};
            end
            tbl[d*10+9] = '{dir: d[0], start: 1'b0, q: 4'b0000, busy: 1'b0, step: 1'b0, wrap: 1'b0, done: 1'b0};
        end

        bus.start = 0; bus.stop_req = 0;
        set_cfg(1, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", obs(), 32'd0);
        rst_n = 1'b1;

        // Directed one-revolution runs in both directions, div=0.
        for (int i = 0; i < 20; i++) begin
            set_cfg(1, 0, tbl[i].dir);
            cycle(tbl[i].start, 1'b0);
            $display("tbl %0d: dir=%0d q=%b busy=%0d step=%0d wrap=%0d done=%0d", i, tbl[i].dir,
                     bus.q, bus.busy, bus.step, bus.wrap, bus.done);
            check($sformatf("tbl_%0d", i), obs(),
                  mk(tbl[i].busy, tbl[i].done, tbl[i].step, tbl[i].wrap, 1'b0, tbl[i].q));
        end

        // div=2, revs=2: a step every third cycle, wraps at steps 8 and 16, one done.
        set_cfg(2, 2, 0);
        cycle(1, 0);
        steps = 0; spacing_bad = 0; done_cnt = 0; done_step = 0; wrap_mask = 0; fin = 0;
        for (int c = 1; c <= 80 && !fin; c++) begin
            cycle(0, 0);
            if (bus.step) begin
                steps++;
                if (c != 3 * steps) spacing_bad++;
                if (bus.wrap) wrap_mask |= 32'd1 << steps;
            end
            if (bus.done) begin done_cnt++; done_step = steps; end
            if (!bus.busy) fin = 1;
        end
        $display("div2 run: %0d steps, wrap mask 0x%0h, %0d done", steps, wrap_mask, done_cnt);
        check("div2_finished", 32'(fin), 32'd1);
        check("div2_steps", 32'(steps), 32'd16);
        check("div2_spacing", 32'(spacing_bad), 32'd0);
        check("div2_wraps", wrap_mask, (32'd1 << 8) | (32'd1 << 16));
        check("div2_done_cnt", 32'(done_cnt), 32'd1);
        check("div2_done_step", 32'(done_step), 32'd16);

        // Free-running, stop requested while q=1110: drains through 1111 to 0000.
        set_cfg(0, 0, 0);
        cycle(1, 0);
        fin = 0;
        for (int c = 0; c < 8 && !fin; c++) begin
            cycle(0, 0);
            if (bus.q == 4'b1110) fin = 1;
        end
        check("drain_reach_1110", 32'(fin), 32'd1);
        cycle(0, 1);
        check("drain_first", obs(), mk(1, 0, 1, 0, 0, 4'b1111));
        for (int k = 0; k < 4; k++) begin
            cycle(0, 0);
            check($sformatf("drain_%0d", k), obs(), mk(1, k == 3, 1, k == 3, 0, drain_q[k]));
        end
        cycle(0, 0);
        check("drain_idle", obs(), 32'd0);
        $display("drain run: finished, busy=%0d", bus.busy);

        // Stop while q=0000 in RUN: done next edge with no step.
        set_cfg(0, 3, 0);
        cycle(1, 0);
        check("stop0_start", obs(), mk(1, 0, 0, 0, 0, 4'b0000));
        cycle(0, 1);
        check("stop0_done", obs(), mk(1, 1, 0, 0, 0, 4'b0000));
        cycle(0, 0);
        check("stop0_idle", obs(), 32'd0);
        $display("stop-at-zero run: finished");

        // A start issued mid-run with a different config is ignored.
        set_cfg(1, 0, 0);
        cycle(1, 0);
        cycle(0, 0);
        cycle(0, 0);
        set_cfg(3, 5, 1);
        cycle(1, 0);
        check("restart_ignored", obs(), mk(1, 0, 1, 0, 0, 4'b1110));
        steps = 0; fin = 0;
        for (int c = 0; c < 20 && !fin; c++) begin
            cycle(0, 0);
            if (bus.step) steps++;
            if (!bus.busy) fin = 1;
        end
        check("restart_finished", 32'(fin), 32'd1);
        check("restart_steps_left", 32'(steps), 32'd5);
        $display("start-while-busy run: %0d further steps", steps);

        // Random commands and configs against the model.
        runs = 0;
        for (int c = 0; c < 3000; c++) begin
            bit st, sp;
            set_cfg($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            st = ($urandom_range(0, 5) == 0);
            sp = ($urandom_range(0, 14) == 0);
            cycle(st, sp);
            check("random", obs(), model_exp());
            if (m_done) begin
                runs++;
                $display("random run %0d: done at cycle %0d, revs counted %0d", runs, c, m_revc);
            end
        end

        fin = 0;
        for (int c = 0; c < 200 && !fin; c++) begin
            cycle(0, 1);
            if (!bus.busy) fin = 1;
        end
        check("random_settle", 32'(fin), 32'd1);

        // Illegal ring code while running: flagged, ring cleared, run ended.
        set_cfg(0, 7, 0);
        cycle(1, 0);
        cycle(0, 0);
        force dut.u_core.q = 4'b0100;
        @(posedge clk);
        #1;
        release dut.u_core.q;
        #1;
        check("illegal_flag", obs(), mk(1, 1, 0, 0, 1, 4'b0000));
        cycle(0, 0);
        check("illegal_idle", obs(), mk(0, 0, 0, 0, 1, 4'b0000));
        cycle(0, 0);
        check("illegal_sticky", obs(), mk(0, 0, 0, 0, 1, 4'b0000));
        set_cfg(0, 0, 0);
        cycle(1, 0);
        check("illegal_cleared", obs(), mk(1, 0, 0, 0, 0, 4'b0000));
        $display("illegal-code run: err_illegal set then cleared by start");

        // Reset mid-run: outputs return to zero immediately, no done afterwards.
        cycle(0, 0);
        cycle(0, 0);
        cycle(0, 0);
        check("pre_reset_q", 32'(bus.q), 32'(4'b1110));
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_async", obs(), 32'd0);
        @(posedge clk);
        #1;
        check("reset_hold", obs(), 32'd0);
        rst_n = 1'b1;
        cycle(0, 0);
        check("reset_release", obs(), 32'd0);
        $display("reset run: outputs cleared");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
